// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the multicycle RV32I controller.
// Holds the main FSM state encoding, the opcodes the controller recognises,
// and the encodings of the datapath mux selects and ALU operation class.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } statetype;

    // Opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// mainfsm: Moore main controller for the multicycle RV32I datapath.
// Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback
// and drives the shared-datapath mux selects and write enables.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset (loads Fetch)
//   op[6:0]             opcode from the instruction register
//   MemReady            memory access completes this cycle
//   Branch, PCUpdate    conditional / unconditional PC write enables
//   RegWrite, MemWrite  register file / data memory write enables
//   IRWrite             instruction register write enable
//   ResultSrc[1:0]      result mux: 00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA[1:0]        ALU A: 00 PC, 01 OldPC, 10 rs1
//   ALUSrcB[1:0]        ALU B: 00 rs2, 01 ImmExt, 10 constant 4
//   AdrSrc              memory address: 0 PC, 1 Result
//   ALUOp[1:0]          to ALU decoder: 00 add, 01 sub, 10 funct-decoded
//   Retire              one-cycle pulse per completed instruction
//   Illegal             high while trapped on an unsupported opcode
module mainfsm
    import riscv_pkg::*;
#(
    parameter bit SUPPORT_ITYPE = 1'b1,
    parameter bit SUPPORT_JAL   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       MemReady,
    output logic       Branch,
    output logic       PCUpdate,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       AdrSrc,
    output logic [1:0] ALUOp,
    output logic       Retire,
    output logic       Illegal
);

    statetype state, next_state;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (MemReady) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = SUPPORT_ITYPE ? S_EXECI : S_TRAP;
                    OP_JAL:       next_state = SUPPORT_JAL   ? S_JAL   : S_TRAP;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (MemReady) next_state = S_FETCH;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    // Outputs are gated by reset so the datapath sees no enables while the
    // controller is held, whatever state the register happens to hold.
    always_comb begin
        Branch    = 1'b0;
        PCUpdate  = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        AdrSrc    = 1'b0;
        ALUOp     = ALUOP_ADD;
        Retire    = 1'b0;
        Illegal   = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    // PC+4 computed and written only on the completing cycle,
                    // so a stalled fetch writes IR/PC exactly once.
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    IRWrite   = MemReady;
                    PCUpdate  = MemReady;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                    Retire    = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    Retire   = MemReady;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_JAL: begin
                    // PC <= OldPC+imm via ALUOut path; rd gets PC+4 next cycle
                    ALUSrcA  = SRCA_OLDPC;
                    ALUSrcB  = SRCB_FOUR;
                    PCUpdate = 1'b1;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    Retire   = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_SUB;
                    Branch  = 1'b1;
                    Retire  = 1'b1;
                end
                S_TRAP:  Illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: directed self-checking bench for mainfsm. Outputs are packed
// into a 16-bit control word and compared against hand-derived constants.
// A second instance with SUPPORT_ITYPE=0 covers the trap path.
module tb_mainfsm;

    // Control word layout:
    // [15]Branch [14]PCUpdate [13]RegWrite [12]MemWrite [11]IRWrite
    // [10:9]ResultSrc [8:7]ALUSrcA [6:5]ALUSrcB [4]AdrSrc [3:2]ALUOp
    // [1]Retire [0]Illegal
    localparam logic [15:0] C_ZERO  = 16'h0000;
    localparam logic [15:0] C_FETCH = 16'h4C40; // MemReady=1
    localparam logic [15:0] C_FSTL  = 16'h0440; // Fetch, MemReady=0
    localparam logic [15:0] C_DEC   = 16'h00A0;
    localparam logic [15:0] C_MADR  = 16'h0120;
    localparam logic [15:0] C_MRD   = 16'h0010;
    localparam logic [15:0] C_MWB   = 16'h2202;
    localparam logic [15:0] C_MWR0  = 16'h1010; // MemWrite, MemReady=0
    localparam logic [15:0] C_MWR1  = 16'h1012; // MemWrite, MemReady=1
    localparam logic [15:0] C_EXR   = 16'h0108;
    localparam logic [15:0] C_EXI   = 16'h0128;
    localparam logic [15:0] C_JAL   = 16'h40C0;
    localparam logic [15:0] C_AWB   = 16'h2002;
    localparam logic [15:0] C_BEQ   = 16'h8106;
    localparam logic [15:0] C_TRAP  = 16'h0001;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0110111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, mr, reset2, mr2;
    logic [6:0] op, op2;
    logic       br, pcu, rw, mw, irw, adr, ret, ill;
    logic [1:0] rs, sa, sb, aop;
    logic       br2, pcu2, rw2, mw2, irw2, adr2, ret2, ill2;
    logic [1:0] rs2, sa2, sb2, aop2;

    int checks = 0;
    int errors = 0;

    mainfsm dut (
        .clk(clk), .reset(reset), .op(op), .MemReady(mr),
        .Branch(br), .PCUpdate(pcu), .RegWrite(rw), .MemWrite(mw),
        .IRWrite(irw), .ResultSrc(rs), .ALUSrcA(sa), .ALUSrcB(sb),
        .AdrSrc(adr), .ALUOp(aop), .Retire(ret), .Illegal(ill)
    );

    mainfsm #(.SUPPORT_ITYPE(1'b0), .SUPPORT_JAL(1'b1)) dut_noi (
        .clk(clk), .reset(reset2), .op(op2), .MemReady(mr2),
        .Branch(br2), .PCUpdate(pcu2), .RegWrite(rw2), .MemWrite(mw2),
        .IRWrite(irw2), .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2),
        .AdrSrc(adr2), .ALUOp(aop2), .Retire(ret2), .Illegal(ill2)
    );

    wire [15:0] ctl  = {br, pcu, rw, mw, irw, rs, sa, sb, adr, aop, ret, ill};
    wire [15:0] ctl2 = {br2, pcu2, rw2, mw2, irw2, rs2, sa2, sb2, adr2, aop2, ret2, ill2};

    // One cycle on the main instance: apply inputs on the falling edge,
    // check the Moore outputs mid-cycle, then advance past the rising edge.
    task automatic cyc(input string tag, input logic r, input logic [6:0] o,
                       input logic m, input logic [15:0] exp);
        reset = r; op = o; mr = m;
        #1;
        checks++;
        assert (ctl === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, ctl, exp);
        end
        @(negedge clk);
    endtask

    task automatic cyc2(input string tag, input logic r, input logic [6:0] o,
                        input logic m, input logic [15:0] exp);
        reset2 = r; op2 = o; mr2 = m;
        #1;
        checks++;
        assert (ctl2 === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, ctl2, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; op = RT; mr = 1'b1;
        reset2 = 1'b1; op2 = IT; mr2 = 1'b1;
        @(negedge clk);

        // Reset held 3 cycles: everything forced low
        for (int i = 0; i < 3; i++) cyc("reset_hold", 1'b1, RT, 1'b1, C_ZERO);

        // lw, no stalls: 5 cycles
        cyc("lw_fetch",  1'b0, RT, 1'b1, C_FETCH);
        cyc("lw_decode", 1'b0, LW, 1'b1, C_DEC);
        cyc("lw_memadr", 1'b0, LW, 1'b1, C_MADR);
        cyc("lw_memrd",  1'b0, LW, 1'b1, C_MRD);
        cyc("lw_memwb",  1'b0, LW, 1'b1, C_MWB);

        // sw with two MemWrite stall cycles
        cyc("sw_fetch",  1'b0, LW, 1'b1, C_FETCH);
        cyc("sw_decode", 1'b0, SW, 1'b0, C_DEC);   // MemReady ignored here
        cyc("sw_memadr", 1'b0, SW, 1'b0, C_MADR);
        cyc("sw_mw0",    1'b0, SW, 1'b0, C_MWR0);
        cyc("sw_mw1",    1'b0, SW, 1'b0, C_MWR0);
        cyc("sw_mw2",    1'b0, SW, 1'b1, C_MWR1);

        // Fetch stall 4 cycles, then single IR/PC write
        for (int i = 0; i < 4; i++) cyc("fetch_stall", 1'b0, SW, 1'b0, C_FSTL);
        cyc("fetch_go",   1'b0, SW,  1'b1, C_FETCH);

        // beq then jal back-to-back
        cyc("beq_decode", 1'b0, BEQ, 1'b1, C_DEC);
        cyc("beq_exec",   1'b0, BEQ, 1'b0, C_BEQ);
        cyc("jal_fetch",  1'b0, BEQ, 1'b1, C_FETCH);
        cyc("jal_decode", 1'b0, JAL, 1'b1, C_DEC);
        cyc("jal_exec",   1'b0, JAL, 1'b1, C_JAL);
        cyc("jal_wb",     1'b0, JAL, 1'b1, C_AWB);

        // R-type and I-type
        cyc("r_fetch",    1'b0, JAL, 1'b1, C_FETCH);
        cyc("r_decode",   1'b0, RT,  1'b1, C_DEC);
        cyc("r_exec",     1'b0, RT,  1'b1, C_EXR);
        cyc("r_wb",       1'b0, RT,  1'b1, C_AWB);
        cyc("i_fetch",    1'b0, RT,  1'b1, C_FETCH);
        cyc("i_decode",   1'b0, IT,  1'b1, C_DEC);
        cyc("i_exec",     1'b0, IT,  1'b1, C_EXI);
        cyc("i_wb",       1'b0, IT,  1'b1, C_AWB);

        // Reset in the middle of a stalled MemRead wins over the hold
        cyc("lw2_fetch",  1'b0, IT, 1'b1, C_FETCH);
        cyc("lw2_decode", 1'b0, LW, 1'b1, C_DEC);
        cyc("lw2_memadr", 1'b0, LW, 1'b1, C_MADR);
        cyc("lw2_memrd",  1'b0, LW, 1'b0, C_MRD);
        cyc("lw2_reset",  1'b1, LW, 1'b0, C_ZERO);
        cyc("lw2_refetch",1'b0, LW, 1'b1, C_FETCH);

        // Unknown opcode traps on the full-featured instance
        cyc("bad_decode", 1'b0, BAD, 1'b1, C_DEC);
        cyc("bad_trap0",  1'b0, BAD, 1'b1, C_TRAP);
        cyc("bad_trap1",  1'b0, LW,  1'b0, C_TRAP);
        reset = 1'b1;

        // SUPPORT_ITYPE=0: I-type traps, sticky until reset
        cyc2("noi_reset",  1'b1, IT, 1'b1, C_ZERO);
        cyc2("noi_fetch",  1'b0, IT, 1'b1, C_FETCH);
        cyc2("noi_decode", 1'b0, IT, 1'b1, C_DEC);
        cyc2("noi_trap0",  1'b0, IT, 1'b1, C_TRAP);
        cyc2("noi_trap1",  1'b0, RT, 1'b0, C_TRAP);
        cyc2("noi_trap2",  1'b0, RT, 1'b1, C_TRAP);
        cyc2("noi_rst",    1'b1, RT, 1'b1, C_ZERO);
        cyc2("noi_after",  1'b0, RT, 1'b1, C_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
